// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: one requester's memory transfer handshake
interface data_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;
  modport master (output req, we, lock, addr, wdata, input ack, rdata);
  modport slave  (input req, we, lock, addr, wdata, output ack, rdata);
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin two-port arbiter with locked bursts onto one data memory port
module data_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave m0,
  data_mem_arbiter_if.slave m1,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DW-1:0]     mem_data_o,
  input  logic [DW-1:0]     mem_data_i,
  output logic [1:0]        grant_o
);
  localparam int BW = $clog2(BURST_MAX) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [BW-1:0] beats_q, beats_d;
  logic          own0, own1, o_req, o_we, o_lock, keep, arb_port;
  // owner's request view; last_q equals the owner while owning, so one tie rule prefers the other port
  always_comb begin
    own0 = state_q == OWN0;
    own1 = state_q == OWN1;
    o_req = own1 ? m1.req : own0 & m0.req;
    o_we = own1 ? m1.we : own0 & m0.we;
    o_lock = own1 ? m1.lock : own0 & m0.lock;
    keep = o_req & o_lock & (beats_q < BW'(BURST_MAX - 1));
    arb_port = (m0.req & m1.req) ? ~last_q : m1.req;
  end
  // hold ownership for a locked beat, otherwise re-arbitrate
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    beats_d = beats_q;
    if (keep) beats_d = beats_q + 1'b1;
    else if (m0.req | m1.req) begin
      state_d = arb_port ? OWN1 : OWN0;
      last_d = arb_port;
      beats_d = '0;
    end else state_d = IDLE;
  end
  // arbitration state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      beats_q <= beats_d;
    end
  end
  // memory mux and acks; reset blocks any commit even mid-burst
  always_comb begin
    mem_ce_o = ~rst & o_req;
    mem_we_o = ~rst & o_we;
    mem_addr_o = own1 ? m1.addr : own0 ? m0.addr : '0;
    mem_data_o = own1 ? m1.wdata : own0 ? m0.wdata : '0;
    m0.ack = ~rst & own0 & m0.req;
    m1.ack = ~rst & own1 & m1.req;
    m0.rdata = own0 ? mem_data_i : '0;
    m1.rdata = own1 ? mem_data_i : '0;
    grant_o = {own1, own0};
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench with a behavioural memory and directed/random traffic
module tb_data_mem_arbiter;
  localparam int BM = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  data_mem_arbiter_if m0_if ();
  data_mem_arbiter_if m1_if ();
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant;
  data_mem_arbiter #(.AW(32), .DW(32), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
    .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .grant_o(grant)
  );
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_ce && mem_we) mem[mem_addr[5:2]] <= mem_wdata;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;
  txn_t q0[$], q1[$];
  int checks = 0, errors = 0;
  bit rec = 0, fair = 0;
  int seq[$];
  int wait_acks [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ack(input int p);
    txn_t e;
    logic [31:0] rd;
    if ((p == 0 ? q0.size() : q1.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack port %0d: ack with no outstanding transfer", p);
      return;
    end
    if (p == 0) e = q0.pop_front();
    else e = q1.pop_front();
    rd = p == 0 ? m0_if.rdata : m1_if.rdata;
    chk($sformatf("grant_p%0d", p), grant, p == 0 ? 2'b01 : 2'b10);
    chk($sformatf("bus_p%0d", p), {mem_ce, mem_we, mem_addr}, {1'b1, e.we, e.addr});
    if (e.we) chk($sformatf("wdata_p%0d", p), mem_wdata, e.wdata);
    else chk($sformatf("rdata_p%0d", p), rd, e.rdata);
  endtask

  // monitor: pops the scoreboard on every ack, logs ack order, bounds contention wait
  always @(negedge clk) begin
    if (rec) seq.push_back(m0_if.ack ? 0 : m1_if.ack ? 1 : 2);
    if (!rst) begin
      if (m0_if.ack) check_ack(0);
      if (m1_if.ack) check_ack(1);
      if (fair) begin
        for (int p = 0; p < 2; p++) begin
          if (p == 0 ? m0_if.ack : m1_if.ack) begin
            checks++;
            if (wait_acks[p] > BM) begin
              errors++;
              $display("FAIL wait_bound port %0d: waited %0d other transfers, limit %0d", p, wait_acks[p], BM);
            end
            wait_acks[p] = 0;
          end else if (p == 0 ? m0_if.req : m1_if.req)
            wait_acks[p] += int'(p == 0 ? m1_if.ack : m0_if.ack);
        end
      end
    end
  end

  task automatic drive(input int p, input logic req, input logic we, input logic lock,
                       input logic [31:0] addr, input logic [31:0] data);
    if (p == 0) begin
      m0_if.req = req; m0_if.we = we; m0_if.lock = lock; m0_if.addr = addr; m0_if.wdata = data;
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.lock = lock; m1_if.addr = addr; m1_if.wdata = data;
    end
  endtask

  task automatic expect_txn(input int p, input logic we, input logic [31:0] addr, input logic [31:0] data);
    txn_t e;
    e.we = we;
    e.addr = addr;
    e.wdata = data;
    e.rdata = ref_mem[addr[5:2]];
    if (we) ref_mem[addr[5:2]] = data;
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic wait_ack(input int p, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p == 0 ? m0_if.ack : m1_if.ack) && n < 64);
    if (!(p == 0 ? m0_if.ack : m1_if.ack)) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout port %0d: no ack within 64 cycles", p);
    end
  endtask

  // one transfer: present at posedge+1, hold to ack, release after the ack edge
  task automatic issue(input int p, input logic we, input logic lock, input logic [31:0] addr, input logic [31:0] data);
    int n;
    expect_txn(p, we, addr, data);
    drive(p, 1'b1, we, lock, addr, data);
    wait_ack(p, n);
    @(posedge clk);
    #1;
    drive(p, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s[%0d]", name, i), i < seq.size() ? seq[i] : -1, exp[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int ec[$];
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst = 1'b1;
    expect_txn(0, 1'b1, 32'h20, 32'h11111111);
    expect_txn(1, 1'b1, 32'h0, 32'h22222222);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h11111111);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h22222222);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ce", mem_ce, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_acks", {m1_if.ack, m0_if.ack}, 2'b00);
      if (i > 0) chk("rst_grant", grant, 2'b00);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_idle_grant", grant, 2'b00);
    chk("rst_no_write_p0", mem[8], 32'h0);
    chk("rst_no_write_p1", mem[0], 32'h0);
    wait_ack(0, n);
    chk("rel_latency", n, 1);
    chk("rel_grant", grant, 2'b01);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_ack(1, n);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    gap(2);
    issue(1, 1'b1, 1'b0, 32'h8, 32'hDEADBEEF);
    issue(1, 1'b0, 1'b0, 32'h8, 32'h0);
    gap(2);
    seq.delete();
    rec = 1;
    fork
      for (int i = 0; i < 4; i++) issue(0, 1'b1, 1'b0, 32'h20 + 4 * i, $urandom);
      for (int j = 0; j < 4; j++) issue(1, 1'b1, 1'b0, 4 * j, $urandom);
    join
    rec = 0;
    ec = '{2, 0, 1, 0, 1, 0, 1, 0, 1};
    check_seq("contend", ec);
    gap(2);
    seq.delete();
    rec = 1;
    fork
      for (int i = 0; i < 6; i++) issue(0, 1'b1, i < 5, 32'h20 + 4 * i, $urandom);
      for (int j = 0; j < 3; j++) issue(1, 1'b0, 1'b0, 4 * j, 32'h0);
    join
    rec = 0;
    ec = '{2, 0, 0, 0, 0, 1, 0, 0, 1, 1};
    check_seq("burst", ec);
    gap(2);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_txn(0, 1'b0, 32'h20, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("withdraw_ce", mem_ce, 1'b0);
    chk("withdraw_grant", grant, 2'b10);
    @(negedge clk);
    chk("withdraw_ack0", m0_if.ack, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    gap(2);
    issue(0, 1'b1, 1'b1, 32'h24, $urandom);
    issue(0, 1'b1, 1'b1, 32'h28, $urandom);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h2C, 32'hBAD0BAD0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_beats_before", dut.beats_q, 2);
    chk("midrst_ack", m0_if.ack, 1'b0);
    chk("midrst_ce_we", {mem_ce, mem_we}, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_beats", dut.beats_q, 0);
    chk("midrst_word", mem[11], ref_mem[11]);
    gap(1);
    wait_acks[0] = 0;
    wait_acks[1] = 0;
    fair = 1;
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        issue(0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 32'h20 + 4 * $urandom_range(0, 7), $urandom);
      end
      for (int j = 0; j < 40; j++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        issue(1, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 4 * $urandom_range(0, 7), $urandom);
      end
    join
    fair = 0;
    gap(3);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
